// File: rtl/clock_display_scan_if.sv
// Bus bundle for clock_display_scan: BCD time and enable in, multiplexed
// seven-segment scan signals out.
interface clock_display_scan_if;
   logic       enable;
   logic [2:0] hr_tens;
   logic [3:0] hr_units;
   logic [2:0] min_tens;
   logic [3:0] min_units;
   logic [3:0] dig_sel;
   logic [6:0] seg;
   logic       colon;
   logic       frame_done;
   logic       err;

   modport master (
      output enable, hr_tens, hr_units, min_tens, min_units,
      input  dig_sel, seg, colon, frame_done, err
   );

   modport slave (
      input  enable, hr_tens, hr_units, min_tens, min_units,
      output dig_sel, seg, colon, frame_done, err
   );
endinterface

// File: rtl/clock_display_scan.sv
// Four-digit HH:MM multiplexed seven-segment scanner with tear-free frame snapshots.
// Optional macro CLOCK_DISPLAY_LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module clock_display_scan #(
   parameter int unsigned SCAN_DIV     = 4,
   parameter int unsigned COLON_FRAMES = 8
) (
   input logic                 clk,
   input logic                 reset,
   clock_display_scan_if.slave bus
);

   localparam int unsigned PRE_W = $clog2(SCAN_DIV);
   localparam int unsigned FC_W  = (COLON_FRAMES > 1) ? $clog2(COLON_FRAMES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
   localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(COLON_FRAMES - 1);
   localparam logic [6:0]       SEG_DASH = 7'h40;
`ifdef CLOCK_DISPLAY_LEADING_ZERO_BLANK_EN
   localparam logic LZ_BLANK = 1'b1;
`else
   localparam logic LZ_BLANK = 1'b0;
`endif

   typedef struct packed {
      logic [2:0] ht;
      logic [3:0] hu;
      logic [2:0] mt;
      logic [3:0] mu;
   } bcd_time_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   function automatic logic time_illegal(input bcd_time_t t);
      logic [6:0] hours;
      hours = 7'(t.ht) * 7'd10 + 7'(t.hu);
      return (t.ht > 3'd2) || (t.hu > 4'd9) || (t.mt > 3'd5) ||
             (t.mu > 4'd9) || (hours > 7'd23);
   endfunction

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [1:0]       idx_q, idx_d;
   bcd_time_t        sh_q, sh_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic             colon_st_q, colon_st_d;
   logic [3:0]       dig_sel_q, dig_sel_d;
   logic [6:0]       seg_q, seg_d;
   logic             colon_q, colon_d;
   logic             frame_done_q, frame_done_d;
   logic             err_q, err_d;

   bcd_time_t  in_time;
   logic       wrap_c;
   logic       capture_c;
   logic       sh_illegal_c;
   logic [3:0] cur_digit_c;

   assign in_time      = '{ht: bus.hr_tens, hu: bus.hr_units,
                           mt: bus.min_tens, mu: bus.min_units};
   assign wrap_c       = (pre_q == PRE_LAST);
   assign capture_c    = bus.enable && wrap_c && (idx_q == 2'd3);
   assign sh_illegal_c = time_illegal(sh_q);

   // Digit currently addressed by the scan, taken from the frame snapshot
   always_comb begin
      cur_digit_c = 4'd0;
      case (idx_q)
         2'd0: cur_digit_c = {1'b0, sh_q.ht};
         2'd1: cur_digit_c = sh_q.hu;
         2'd2: cur_digit_c = {1'b0, sh_q.mt};
         2'd3: cur_digit_c = sh_q.mu;
         default: cur_digit_c = 4'd0;
      endcase
   end

   always_comb begin
      pre_d        = pre_q;
      idx_d        = idx_q;
      sh_d         = sh_q;
      fcnt_d       = fcnt_q;
      colon_st_d   = colon_st_q;
      dig_sel_d    = 4'b0000;
      seg_d        = 7'h00;
      colon_d      = 1'b0;
      frame_done_d = 1'b0;
      err_d        = err_q;

      if (bus.enable) begin
         pre_d = wrap_c ? '0 : pre_q + PRE_W'(1);
         if (wrap_c) idx_d = idx_q + 2'd1;

         dig_sel_d = 4'b0001 << idx_q;
         if (sh_illegal_c)
            seg_d = SEG_DASH;
         else if (LZ_BLANK && (idx_q == 2'd0) && (sh_q.ht == 3'd0))
            seg_d = 7'h00;
         else
            seg_d = seg_encode(cur_digit_c);

         // Frame boundary: latch the new snapshot and advance the colon cadence
         if (capture_c) begin
            sh_d         = in_time;
            frame_done_d = 1'b1;
            err_d        = time_illegal(in_time);
            if (fcnt_q == FC_LAST) begin
               fcnt_d     = '0;
               colon_st_d = ~colon_st_q;
            end else begin
               fcnt_d = fcnt_q + FC_W'(1);
            end
         end
         colon_d = colon_st_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q        <= '0;
         idx_q        <= 2'd0;
         sh_q         <= '0;
         fcnt_q       <= '0;
         colon_st_q   <= 1'b0;
         dig_sel_q    <= 4'b0000;
         seg_q        <= 7'h00;
         colon_q      <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         pre_q        <= pre_d;
         idx_q        <= idx_d;
         sh_q         <= sh_d;
         fcnt_q       <= fcnt_d;
         colon_st_q   <= colon_st_d;
         dig_sel_q    <= dig_sel_d;
         seg_q        <= seg_d;
         colon_q      <= colon_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign bus.dig_sel    = dig_sel_q;
   assign bus.seg        = seg_q;
   assign bus.colon      = colon_q;
   assign bus.frame_done = frame_done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Randomized self-checking bench for clock_display_scan against a frame-level
// model of the scan (enabled-edge count -> digit, frame, colon phase).
module tb_clock_display_scan;
   localparam int SD = 4;
   localparam int CF = 8;
   localparam int FR = SD * 4;
`ifdef CLOCK_DISPLAY_LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   clock_display_scan_if bus ();

   clock_display_scan #(.SCAN_DIV(SD), .COLON_FRAMES(CF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: n = enabled edges since reset; snaps[f] = snapshot shown in frame f
   int          n = 0;
   logic [13:0] snaps [int];
   logic [3:0]  e_dig;
   logic [6:0]  e_seg;
   logic        e_colon, e_fd, e_err;

   function automatic int dig_of(logic [13:0] s, int i);
      case (i)
         0: return int'(s[13:11]);
         1: return int'(s[10:7]);
         2: return int'(s[6:4]);
         default: return int'(s[3:0]);
      endcase
   endfunction

   function automatic bit illegal_t(logic [13:0] s);
      int ht, hu, mt, mu;
      ht = dig_of(s, 0); hu = dig_of(s, 1); mt = dig_of(s, 2); mu = dig_of(s, 3);
      return ht > 2 || hu > 9 || mt > 5 || mu > 9 || (ht * 10 + hu) > 23;
   endfunction

   function automatic logic [6:0] seg7(int d);
      logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return tbl[d];
   endfunction

   function automatic logic [6:0] exp_seg_for(logic [13:0] s, int i);
      if (illegal_t(s)) return 7'h40;
      if (i == 0 && LZ && dig_of(s, 0) == 0) return 7'h00;
      return seg7(dig_of(s, i));
   endfunction

   task automatic chk(string nm, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
      end
   endtask

   always @(posedge clk) begin : model
      logic [13:0] s;
      int idx;
      if (!reset) begin
         n = 0;
         snaps.delete();
         snaps[0] = 14'd0;
         e_dig = 4'd0; e_seg = 7'd0; e_colon = 1'b0; e_fd = 1'b0; e_err = 1'b0;
      end else if (bus.enable) begin
         idx = (n / SD) % 4;
         s = snaps[n / FR];
         n++;
         if (n % FR == 0)
            snaps[n / FR] = {bus.hr_tens, bus.hr_units, bus.min_tens, bus.min_units};
         e_dig   = 4'(1 << idx);
         e_seg   = exp_seg_for(s, idx);
         e_fd    = (n % FR == 0);
         e_colon = ((n / FR) / CF) % 2 == 1;
         e_err   = illegal_t(snaps[n / FR]);
      end else begin
         e_dig = 4'd0; e_seg = 7'd0; e_colon = 1'b0; e_fd = 1'b0;
         e_err = illegal_t(snaps[n / FR]);
      end
      #1;
      chk("cyc_dig_sel", int'(bus.dig_sel), int'(e_dig));
      chk("cyc_seg", int'(bus.seg), int'(e_seg));
      chk("cyc_colon", int'(bus.colon), int'(e_colon));
      chk("cyc_frame_done", int'(bus.frame_done), int'(e_fd));
      chk("cyc_err", int'(bus.err), int'(e_err));
   end

   task automatic set_time(int ht, int hu, int mt, int mu);
      bus.hr_tens = 3'(ht); bus.hr_units = 4'(hu);
      bus.min_tens = 3'(mt); bus.min_units = 4'(mu);
   endtask

   task automatic wait_n(int target);
      int guard = 0;
      while (n < target && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (n < target) chk("wait_budget", n, target);
   endtask

   task automatic rand_run_to(int target);
      int guard = 0;
      forever begin
         @(negedge clk);
         guard++;
         if (n >= target) break;
         if (guard > 5000) begin
            chk("rand_budget", n, target);
            break;
         end
         bus.enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 3) == 0) begin
               set_time($urandom_range(0, 7), $urandom_range(0, 15),
                        $urandom_range(0, 7), $urandom_range(0, 15));
            end else begin
               int ht = $urandom_range(0, 2);
               set_time(ht, (ht == 2) ? $urandom_range(0, 3) : $urandom_range(0, 9),
                        $urandom_range(0, 5), $urandom_range(0, 9));
            end
         end
      end
      bus.enable = 1'b1;
   endtask

   task automatic chk_out(string nm, int dig, int seg);
      chk({nm, "_dig_sel"}, int'(bus.dig_sel), dig);
      chk({nm, "_seg"}, int'(bus.seg), seg);
   endtask

   // Fixed expectations for the first frames after reset with 12:34 applied
   task automatic first_frame_checks();
      wait_n(1);
      chk_out("f0_d0", 1, LZ ? 'h00 : 'h3F);
      chk("f0_fd", int'(bus.frame_done), 0);
      chk("f0_err", int'(bus.err), 0);
      wait_n(15);  chk("f0_fd15", int'(bus.frame_done), 0);
      wait_n(16);  chk("f0_fd16", int'(bus.frame_done), 1);
      chk_out("f0_d3", 8, 'h3F);
      wait_n(17);  chk_out("f1_d0", 1, 'h06);
      chk("f1_fd", int'(bus.frame_done), 0);
      wait_n(21);  chk_out("f1_d1", 2, 'h5B);
      wait_n(25);  chk_out("f1_d2", 4, 'h4F);
      wait_n(29);  chk_out("f1_d3", 8, 'h66);
   endtask

   initial begin
      reset = 1'b1;
      bus.enable = 1'b0;
      set_time(0, 0, 0, 0);
      #1 reset = 1'b0;
      #1;
      chk_out("rst", 0, 0);
      chk("rst_colon", int'(bus.colon), 0);
      chk("rst_fd", int'(bus.frame_done), 0);
      chk("rst_err", int'(bus.err), 0);
      @(negedge clk); @(negedge clk);
      set_time(1, 2, 3, 4);
      bus.enable = 1'b1;
      reset = 1'b1;
      first_frame_checks();

      // Input change while digit 1 is on screen must not tear the frame
      wait_n(38);  set_time(0, 7, 5, 0);
      wait_n(41);  chk_out("tear_d2", 4, 'h4F);
      wait_n(45);  chk_out("tear_d3", 8, 'h66);
      wait_n(48);  chk("tear_fd", int'(bus.frame_done), 1);
      wait_n(49);  chk_out("new_d0", 1, LZ ? 'h00 : 'h3F);
      wait_n(53);  chk_out("new_d1", 2, 'h07);
      wait_n(57);  chk_out("new_d2", 4, 'h6D);
      wait_n(61);  chk_out("new_d3", 8, 'h3F);

      set_time(2, 4, 0, 0);
      wait_n(64);  chk("ill_err", int'(bus.err), 1);
      wait_n(65);  chk_out("ill_d0", 1, 'h40);
      wait_n(69);  chk_out("ill_d1", 2, 'h40);
      set_time(2, 3, 5, 9);
      wait_n(80);  chk("ok_err", int'(bus.err), 0);
      wait_n(81);  chk_out("ok_d0", 1, 'h5B);
      wait_n(85);  chk_out("ok_d1", 2, 'h4F);
      wait_n(89);  chk_out("ok_d2", 4, 'h6D);

      // Freeze mid-digit for 10 cycles
      bus.enable = 1'b0;
      @(negedge clk);
      chk_out("frz", 0, 0);
      chk("frz_colon", int'(bus.colon), 0);
      repeat (9) @(negedge clk);
      bus.enable = 1'b1;
      wait_n(90);  chk_out("res_a", 4, 'h6D);
      wait_n(92);  chk_out("res_c", 4, 'h6D);
      wait_n(93);  chk_out("res_d3", 8, 'h6F);

      rand_run_to(127); chk("colon127", int'(bus.colon), 0);
      wait_n(128);      chk("colon128", int'(bus.colon), 1);
      chk("fd128", int'(bus.frame_done), 1);
      rand_run_to(255); chk("colon255", int'(bus.colon), 1);
      wait_n(256);      chk("colon256", int'(bus.colon), 0);

      // Asynchronous reset between clock edges
      set_time(1, 2, 3, 4);
      bus.enable = 1'b1;
      wait_n(262);
      #2 reset = 1'b0;
      #1;
      chk_out("arst", 0, 0);
      chk("arst_colon", int'(bus.colon), 0);
      chk("arst_fd", int'(bus.frame_done), 0);
      chk("arst_err", int'(bus.err), 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      first_frame_checks();
      rand_run_to(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_display_scan.md
CLOCK_DISPLAY_SCAN -- requirements
Module: clock_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clk cycles each digit is displayed (>=2).
REQ-002 SHALL have parameter COLON_FRAMES, default 8: completed frames per colon toggle (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset; reset=0 clears all state immediately.
REQ-005 SHALL have port enable  input  1  scan enable; 0 freezes scan and blanks the display.
REQ-006 SHALL have port hr_tens  input  3  BCD hours tens, legal 0..2.
REQ-007 SHALL have port hr_units  input  4  BCD hours units, legal 0..9, with hours <= 23.
REQ-008 SHALL have port min_tens  input  3  BCD minutes tens, legal 0..5.
REQ-009 SHALL have port min_units  input  4  BCD minutes units, legal 0..9.
REQ-010 SHALL have port dig_sel  output  4  one-hot active-high digit select; bit0=hr_tens, bit1=hr_units, bit2=min_tens, bit3=min_units.
REQ-011 SHALL have port seg  output  7  active-high segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port colon  output  1  colon LED, active-high.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when a new snapshot is captured.
REQ-014 SHALL have port err  output  1  high for the whole frame whose snapshot is an illegal time.

Function
REQ-015 SHALL keep prescaler pre (0..SCAN_DIV-1) and digit index idx (0..3); per enabled cycle pre increments, and at pre=SCAN_DIV-1 pre wraps to 0 and idx advances 0->1->2->3->0.
REQ-016 SHALL, on the enabled edge with pre=SCAN_DIV-1 and idx=3, capture all four inputs into a shadow register, pulse frame_done for one cycle, and update err from the captured value.
REQ-017 SHALL display only shadow contents, so an input change mid-frame never alters a frame in progress (no tearing).
REQ-018 SHALL register all outputs; dig_sel/seg for index idx appear one cycle after idx takes that value, and seg always belongs to the digit selected in the same cycle.
REQ-019 SHALL encode 0..9 as 3F,06,5B,4F,66,6D,7D,07,7F,6F hex and dash as 40 hex.
REQ-020 SHALL flag the snapshot illegal if any digit exceeds its legal range or hours > 23; err=1 and all four digits show dash for that frame.
REQ-021 SHALL, while enable=0, hold pre, idx, shadow, frame count and colon state, and drive dig_sel=0000, seg=0, colon=0 from the next edge; on re-enable scanning resumes from the held pre/idx.
REQ-022 SHALL count frame_done pulses modulo COLON_FRAMES and toggle an internal colon state on each wrap; colon output = colon state while enabled.
REQ-023 SHALL display, for the first frame after reset, the reset shadow value 00:00 with err=0.

Reset
REQ-024 SHALL, while reset=0, force pre=0, idx=0, shadow=0, frame count=0, colon state=0, and outputs dig_sel=0000, seg=0, colon=0, frame_done=0, err=0, independent of clk.
REQ-025 SHALL, on reset assertion mid-frame, abandon the frame; after release the first enabled cycle starts at idx=0, pre=0.

Configuration
REQ-026 SHALL, with macro CLOCK_DISPLAY_LEADING_ZERO_BLANK_EN defined, drive seg=0 on digit 0 when shadow hr_tens=0 and err=0; without it, digit 0 shows 3F; dash on error takes precedence in both builds.

Verification (SCAN_DIV=4, COLON_FRAMES=8)
REQ-027 SHALL test: reset, inputs 12:34, enable=1 -> first frame 00:00 (digit0 blank if macro), frame_done on 16th enabled edge, then dig_sel 0001/0010/0100/1000 with seg 06/5B/4F/66, 4 cycles each.
REQ-028 SHALL test: inputs 24:00 -> next frame err=1, all digits seg=40; inputs 23:59 -> following frame err=0, seg 5B/4F/6D/6F.
REQ-029 SHALL test: change 12:34 to 07:50 while digit 1 is shown -> current frame completes as 12:34; 07:50 appears only after next frame_done.
REQ-030 SHALL test: enable=0 for 10 cycles during digit 2 after 1 of its 4 cycles -> dig_sel=0000, seg=0, colon=0; after re-enable digit 2 shown 3 more cycles, then digit 3.
REQ-031 SHALL test: continuous enable -> colon rises after 8th frame_done (edge 128), falls after 16th (edge 256).
REQ-032 SHALL test: reset=0 asynchronously mid-digit between clk edges -> all outputs 0 immediately; after release behaviour matches REQ-027.
